// File: rtl/reflet_int_to_float_seq.sv
// rtl/reflet_int_to_float_seq.sv - multi-cycle signed integer to reflet float converter
// Optional round-to-nearest-even of discarded mantissa bits: define REFLET_FLOAT_ROUND_EN
module reflet_int_to_float_seq #(
   parameter int int_size   = 16,
   parameter int float_size = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [int_size-1:0]   int_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [float_size-1:0] float_out,
   output logic                  busy
);
   function automatic int exp_bits(input int fs);
      if (fs >= 64)
         return 11;
      else if (fs >= 32)
         return 8;
      else
         return 5;
   endfunction

   localparam int ew = exp_bits(float_size);
   localparam int mw = float_size - 1 - ew;
   localparam int fw = int_size - 1;
   localparam int kw = (int_size > 2) ? $clog2(int_size) : 1;
   localparam logic [ew-1:0] exp_top = ew'(fw + (2 ** (ew - 1)) - 1);

   typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

   state_t              state;
   logic                sign;
   logic [int_size-1:0] mag;
   logic [kw-1:0]       k;

   logic [int_size-1:0] abs_in;
   logic [fw-1:0]       frac;
   logic [mw-1:0]       mant_c;
   logic                carry_c;
   logic [ew-1:0]       exp_c;

   assign abs_in = int_in[int_size-1] ? -int_in : int_in;
   assign frac   = mag[fw-1:0];

   generate
      if (fw <= mw) begin : g_pad
         if (fw == mw) begin : g_exact
            assign mant_c = frac;
         end else begin : g_zero
            assign mant_c = {frac, {(mw - fw){1'b0}}};
         end
         assign carry_c = 1'b0;
      end else begin : g_narrow
         localparam int dw = fw - mw;
         logic [mw-1:0] kept;
         assign kept = frac[fw-1:dw];
`ifdef REFLET_FLOAT_ROUND_EN
         logic          guard;
         logic          sticky;
         logic          round_up;
         logic [mw:0]   sum;
         assign guard = frac[dw-1];
         if (dw > 1) begin : g_sticky
            assign sticky = |frac[dw-2:0];
         end else begin : g_no_sticky
            assign sticky = 1'b0;
         end
         // Ties go to the even mantissa; an all-ones mantissa wraps into the exponent.
         assign round_up = guard & (sticky | kept[0]);
         assign sum      = {1'b0, kept} + {{mw{1'b0}}, round_up};
         assign mant_c   = sum[mw-1:0];
         assign carry_c  = sum[mw];
`else
         assign mant_c  = kept;
         assign carry_c = 1'b0;
`endif
      end
   endgenerate

   assign exp_c = exp_top - ew'(k) + ew'(carry_c);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         sign      <= 1'b0;
         mag       <= '0;
         k         <= '0;
         float_out <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sign  <= int_in[int_size-1];
                  mag   <= abs_in;
                  k     <= '0;
                  state <= NORM;
               end
            end
            NORM: begin
               if (mag == '0) begin
                  float_out <= '0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (mag[fw]) begin
                  float_out <= {sign, exp_c, mant_c};
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  mag <= mag << 1;
                  k   <= k + kw'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_reflet_int_to_float_seq.sv
// tb/tb_reflet_int_to_float_seq.sv - randomized self-checking bench for reflet_int_to_float_seq
module tb_reflet_int_to_float_seq;
   logic        clk = 1'b0;
   logic        reset = 1'b0;

   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] int_in = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] float_out;
   logic        busy;

   logic        in_valid32 = 1'b0;
   logic        in_ready32;
   logic [31:0] int_in32 = '0;
   logic        out_valid32;
   logic        out_ready32 = 1'b1;
   logic [31:0] float_out32;
   logic        busy32;

   int          n_pass = 0;
   int          n_total = 0;
   int          tmo = 0;
   int          ready_mode = 0;
   logic        finish_req = 1'b0;
   logic        final_done = 1'b0;

   always #5 clk = ~clk;

   reflet_int_to_float_seq #(.int_size(16), .float_size(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .int_in(int_in),
      .out_valid(out_valid), .out_ready(out_ready), .float_out(float_out), .busy(busy)
   );

   reflet_int_to_float_seq #(.int_size(32), .float_size(32)) dut32 (
      .clk(clk), .reset(reset), .in_valid(in_valid32), .in_ready(in_ready32), .int_in(int_in32),
      .out_valid(out_valid32), .out_ready(out_ready32), .float_out(float_out32), .busy(busy32)
   );

   // Reference: exact value |x| = 2^e * 1.f, latency = leading zeros + 1.
   function automatic logic [31:0] ref_float(input longint x, input int isz, output int lat);
      longint a;
      longint m;
      longint rem;
      longint half;
      int     e;
      int     eb;
      int     sh;
      if (x == 0) begin
         lat = 1;
         return 32'h0;
      end
      a = (x < 0) ? -x : x;
      e = 0;
      while ((a >> (e + 1)) != 0) e++;
      lat = isz - e;
      if (e <= 23) begin
         m = (a - (64'sd1 << e)) << (23 - e);
      end else begin
         sh   = e - 23;
         m    = (a - (64'sd1 << e)) >> sh;
         rem  = a & ((64'sd1 << sh) - 1);
         half = 64'sd1 << (sh - 1);
`ifdef REFLET_FLOAT_ROUND_EN
         if (rem > half || (rem == half && m[0])) m++;
`else
         if (rem > half && rem < 0) m++;
`endif
      end
      eb = e + 127;
      if (m == (64'sd1 << 23)) begin
         m  = 0;
         eb = eb + 1;
      end
      return {(x < 0) ? 1'b1 : 1'b0, 8'(eb), 23'(m)};
   endfunction

   task automatic chk(input string name, input longint got, input longint want);
      n_total++;
      if (got == want)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
   endtask

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'b0;
         default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   int          edges, exp_lat, edges32, exp_lat32;
   bit          pending, holding, drop, pending32, pinned;
   logic [31:0] exp_val, hold_val, exp_val32, pin_v;

   // Accepts are recorded at rising edges; outputs are judged at falling edges.
   always @(posedge clk or negedge clk) begin
      int l;
      if (clk) begin
         if (!reset) begin
            pending   = 0;
            holding   = 0;
            drop      = 0;
            pending32 = 0;
         end else begin
            if (pending) edges++;
            if (pending32) edges32++;
            if (holding && out_valid && out_ready) drop = 1;
            if (in_valid && in_ready) begin
               exp_val = ref_float(longint'($signed(int_in)), 16, l);
               exp_lat = l;
               edges   = 0;
               pending = 1;
            end
            if (in_valid32 && in_ready32) begin
               exp_val32 = ref_float(longint'($signed(int_in32)), 32, l);
               exp_lat32 = l;
               edges32   = 0;
               pending32 = 1;
            end
         end
      end else begin
         if (!pinned) begin
            pinned = 1;
            pin_v = ref_float(0, 16, l);          chk("pin_zero", longint'(pin_v), 64'h0);
                                                   chk("pin_zero_lat", l, 1);
            pin_v = ref_float(-32768, 16, l);     chk("pin_min", longint'(pin_v), 64'hC7000000);
                                                   chk("pin_min_lat", l, 1);
            pin_v = ref_float(1, 16, l);          chk("pin_one", longint'(pin_v), 64'h3F800000);
                                                   chk("pin_one_lat", l, 16);
            pin_v = ref_float(-1, 16, l);         chk("pin_neg_one", longint'(pin_v), 64'hBF800000);
            pin_v = ref_float(12345, 16, l);      chk("pin_12345", longint'(pin_v), 64'h4640E400);
                                                   chk("pin_12345_lat", l, 3);
            pin_v = ref_float(64'h01000001, 32, l); chk("pin32_tie_even", longint'(pin_v), 64'h4B800000);
            pin_v = ref_float(64'h01000003, 32, l);
`ifdef REFLET_FLOAT_ROUND_EN
            chk("pin32_round", longint'(pin_v), 64'h4B800002);
`else
            chk("pin32_trunc", longint'(pin_v), 64'h4B800001);
`endif
         end
         if (finish_req && !final_done) begin
            chk("timeouts", tmo, 0);
            chk("nothing_pending", longint'(pending | pending32), 0);
            final_done = 1'b1;
         end
         if (!reset) begin
            chk("rst_out_valid", longint'(out_valid), 0);
            chk("rst_in_ready", longint'(in_ready), 1);
            chk("rst_busy", longint'(busy), 0);
            chk("rst_float_out", longint'(float_out), 0);
            chk("rst32_out_valid", longint'(out_valid32), 0);
            chk("rst32_float_out", longint'(float_out32), 0);
         end else begin
            chk("in_ready_vs_busy", longint'(in_ready), longint'(!busy));
            if (pending && out_valid) begin
               chk("latency", edges, exp_lat);
               chk("result", longint'(float_out), longint'(exp_val));
               pending  = 0;
               holding  = 1;
               drop     = 0;
               hold_val = float_out;
            end else if (holding) begin
               if (drop) begin
                  chk("valid_drop", longint'(out_valid), 0);
                  holding = 0;
                  drop    = 0;
               end else begin
                  chk("hold_valid", longint'(out_valid), 1);
                  chk("hold_stable", longint'(float_out), longint'(hold_val));
               end
            end else begin
               chk("no_spurious_valid", longint'(out_valid), 0);
            end
            if (pending32 && out_valid32) begin
               chk("latency32", edges32, exp_lat32);
               chk("result32", longint'(float_out32), longint'(exp_val32));
               pending32 = 0;
            end
         end
      end
   end

   task automatic send(input logic [15:0] v);
      int t;
      in_valid = 1'b1;
      int_in   = v;
      t = 0;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) tmo++;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send32(input logic [31:0] v);
      int t;
      in_valid32 = 1'b1;
      int_in32   = v;
      t = 0;
      while (!in_ready32 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) tmo++;
      @(posedge clk);
      #1;
      in_valid32 = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((busy || busy32) && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 300) tmo++;
   endtask

   initial begin
      logic signed [15:0] r;
      logic signed [31:0] r32;
      int t;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      send(16'h0000);
      send(16'h8000);
      send(16'h0001);
      send(16'hFFFF);
      send(16'd12345);
      send(16'hFFFB);
      drain();

      ready_mode = 1;
      send(16'd300);
      t = 0;
      while (!out_valid && t < 50) begin
         @(posedge clk);
         t++;
      end
      if (t >= 50) tmo++;
      repeat (10) @(posedge clk);
      #1 ready_mode = 0;
      drain();

      send(16'h0001);
      repeat (4) @(posedge clk);
      #3 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      send(16'd12345);
      drain();

      ready_mode = 2;
      for (int i = 0; i < 100; i++) begin
         r = 16'($urandom);
         r = r >>> $urandom_range(0, 15);
         send(r);
      end
      ready_mode = 0;
      drain();

      send32(32'h01000003);
      send32(32'h01000001);
      send32(32'h80000000);
      send32(32'h00000001);
      for (int i = 0; i < 12; i++) begin
         r32 = $urandom;
         r32 = r32 >>> $urandom_range(0, 31);
         send32(r32);
      end
      drain();
      repeat (2) @(posedge clk);

      finish_req = 1'b1;
      t = 0;
      while (!final_done && t < 10) begin
         @(posedge clk);
         t++;
      end
      if (!final_done) $display("FAIL final_check: not reached");
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
